// File: rtl/sdc_wb_traffic_gen.sv
// Traffic generator for sdc_controller self-test: replays a table of Wishbone
// slave accesses, answers the controller's DMA master port with a fixed ack
// latency, and drives pseudo-random SD card lines.
module sdc_wb_traffic_gen #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 32,
  parameter int unsigned N_ENTRY   = 16,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned M_ACK_LAT = 9,
  parameter int unsigned SD_HOLD   = 10,
  localparam int unsigned IW       = $clog2(N_ENTRY),
  localparam int unsigned NW       = IW + 1,
  localparam int unsigned SELW     = DW / 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            start_i,
  input  logic [NW-1:0]   n_entry_i,
  input  logic [7:0]      passes_i,
  input  logic            tbl_we_i,
  input  logic [IW-1:0]   tbl_idx_i,
  input  logic [AW-1:0]   tbl_adr_i,
  input  logic            tbl_wr_i,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [SELW-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            m_wb_cyc_i,
  input  logic            m_wb_stb_i,
  output logic            m_wb_ack_o,
  output logic [DW-1:0]   m_wb_dat_o,
  input  logic            sd_en_i,
  output logic [3:0]      sd_dat_o,
  output logic            sd_cmd_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            timeout_o,
  output logic [15:0]     xfer_cnt_o,
  output logic [DW-1:0]   rd_sig_o
);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int unsigned TW        = $clog2(TIMEOUT + 2);
  localparam int unsigned MW        = $clog2(M_ACK_LAT + 2);
  localparam int unsigned SDW       = $clog2(SD_HOLD + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_e;

  // 32-bit Galois LFSR, right shift
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // Access table (not reset)
  logic [AW-1:0]      tbl_adr_q [N_ENTRY];
  logic [N_ENTRY-1:0] tbl_wr_q;

  state_e          state_q, state_d;
  logic [IW-1:0]   entry_q, entry_d;
  logic [7:0]      pass_q, pass_d;
  logic [NW-1:0]   n_entry_q, n_entry_d;
  logic [7:0]      passes_q, passes_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic [31:0]     lfsr_s_q, lfsr_s_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic [15:0]     xfer_q, xfer_d;
  logic [DW-1:0]   rd_sig_q, rd_sig_d;

  logic            issue;
  logic [IW-1:0]   issue_idx;
  logic [NW-1:0]   entry_inc;
  logic [7:0]      pass_inc;

  logic [MW-1:0]   m_cnt_q, m_cnt_d;
  logic            m_ack_q, m_ack_d;
  logic [31:0]     m_lfsr_q, m_lfsr_d;

  logic [SDW-1:0]  sd_cnt_q, sd_cnt_d;
  logic [31:0]     sd_lfsr_q, sd_lfsr_d;
  logic [31:0]     sd_next;
  logic [3:0]      sd_dat_q, sd_dat_d;
  logic            sd_cmd_q, sd_cmd_d;

  assign entry_inc = NW'(entry_q) + NW'(1);
  assign pass_inc  = pass_q + 8'd1;
  assign sd_next   = lfsr_step(sd_lfsr_q);

  // Table programming, accepted only while idle
  always_ff @(posedge wb_clk_i) begin
    if (tbl_we_i && (state_q == S_IDLE)) begin
      tbl_adr_q[tbl_idx_i] <= tbl_adr_i;
      tbl_wr_q[tbl_idx_i]  <= tbl_wr_i;
    end
  end

  // Sequencer next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    pass_d    = pass_q;
    n_entry_d = n_entry_q;
    passes_d  = passes_q;
    wait_d    = wait_q;
    lfsr_s_d  = lfsr_s_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    xfer_d    = xfer_q;
    rd_sig_d  = rd_sig_q;
    issue     = 1'b0;
    issue_idx = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          entry_d   = '0;
          pass_d    = '0;
          timeout_d = 1'b0;
          xfer_d    = '0;
          rd_sig_d  = '0;
          n_entry_d = (n_entry_i > NW'(N_ENTRY)) ? NW'(N_ENTRY) : n_entry_i;
          passes_d  = passes_i;
          if ((n_entry_i == '0) || (passes_i == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            issue = 1'b1;
          end
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        wait_d  = TW'(1);
      end
      S_WAIT: begin
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          state_d = S_GAP;
          if (xfer_q != 16'hFFFF) xfer_d = xfer_q + 16'd1;
          if (we_q) lfsr_s_d = lfsr_step(lfsr_s_q);
          else      rd_sig_d = {rd_sig_q[DW-2:0], rd_sig_q[DW-1]} ^ wb_dat_i;
        end else if (wait_q == TW'(TIMEOUT)) begin
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          sel_d     = '0;
          timeout_d = 1'b1;
          state_d   = S_GAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_GAP: begin
        if (entry_inc == n_entry_q) begin
          entry_d = '0;
          if (pass_inc == passes_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            pass_d = pass_inc;
            issue  = 1'b1;
          end
        end else begin
          entry_d   = entry_inc[IW-1:0];
          issue_idx = entry_inc[IW-1:0];
          issue     = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue) begin
      state_d = S_REQ;
      cyc_d   = 1'b1;
      adr_d   = tbl_adr_q[issue_idx];
      we_d    = tbl_wr_q[issue_idx];
      dat_d   = lfsr_s_q[DW-1:0];
      sel_d   = '1;
      wait_d  = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // Sequencer state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q   <= S_IDLE;
      entry_q   <= '0;
      pass_q    <= '0;
      n_entry_q <= '0;
      passes_q  <= '0;
      wait_q    <= '0;
      lfsr_s_q  <= SEED;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      xfer_q    <= '0;
      rd_sig_q  <= '0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      pass_q    <= pass_d;
      n_entry_q <= n_entry_d;
      passes_q  <= passes_d;
      wait_q    <= wait_d;
      lfsr_s_q  <= lfsr_s_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      xfer_q    <= xfer_d;
      rd_sig_q  <= rd_sig_d;
    end
  end

  // DMA master responder: ack after M_ACK_LAT+1 strobed cycles, data steps after each ack
  always_comb begin
    m_cnt_d  = m_cnt_q;
    m_ack_d  = 1'b0;
    m_lfsr_d = m_lfsr_q;
    if (m_ack_q) m_lfsr_d = lfsr_step(m_lfsr_q);
    if (m_wb_cyc_i && m_wb_stb_i) begin
      if (m_cnt_q == MW'(M_ACK_LAT)) begin
        m_ack_d = 1'b1;
        m_cnt_d = '0;
      end else begin
        m_cnt_d = m_cnt_q + 1'b1;
      end
    end else begin
      m_cnt_d = '0;
    end
  end

  // SD line driver: new random value every SD_HOLD cycles, idle lines when disabled
  always_comb begin
    sd_cnt_d  = sd_cnt_q;
    sd_lfsr_d = sd_lfsr_q;
    sd_dat_d  = sd_dat_q;
    sd_cmd_d  = sd_cmd_q;
    if (sd_en_i) begin
      if (sd_cnt_q == SDW'(SD_HOLD - 1)) begin
        sd_cnt_d  = '0;
        sd_lfsr_d = sd_next;
        sd_dat_d  = sd_next[3:0];
        sd_cmd_d  = sd_next[4];
      end else begin
        sd_cnt_d = sd_cnt_q + 1'b1;
      end
    end else begin
      sd_cnt_d = '0;
      sd_dat_d = 4'hF;
      sd_cmd_d = 1'b1;
    end
  end

  // Master responder and SD driver registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      m_cnt_q   <= '0;
      m_ack_q   <= 1'b0;
      m_lfsr_q  <= SEED;
      sd_cnt_q  <= '0;
      sd_lfsr_q <= SEED;
      sd_dat_q  <= 4'hF;
      sd_cmd_q  <= 1'b1;
    end else begin
      m_cnt_q   <= m_cnt_d;
      m_ack_q   <= m_ack_d;
      m_lfsr_q  <= m_lfsr_d;
      sd_cnt_q  <= sd_cnt_d;
      sd_lfsr_q <= sd_lfsr_d;
      sd_dat_q  <= sd_dat_d;
      sd_cmd_q  <= sd_cmd_d;
    end
  end

  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;
  assign wb_we_o    = we_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign m_wb_ack_o = m_ack_q;
  assign m_wb_dat_o = m_lfsr_q[DW-1:0];
  assign sd_dat_o   = sd_dat_q;
  assign sd_cmd_o   = sd_cmd_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign timeout_o  = timeout_q;
  assign xfer_cnt_o = xfer_q;
  assign rd_sig_o   = rd_sig_q;

endmodule
